// File: rtl/dmem_wbuf.sv
`default_nettype none
// ============================================================================
// Module   : dmem_wbuf
// Purpose  : Data memory with a posted write buffer. CPU stores are queued in
//            a small FIFO and drained into a single-ported array one per
//            cycle whenever the array is not busy serving a load. Loads are
//            answered combinationally, with store-to-load forwarding from the
//            youngest matching buffered store.
// Ports    : clk          - system clock, rising edge
//            reset        - asynchronous, active-low reset
//            MemRd        - load request
//            MemWr        - store request
//            address      - word address (upper bits beyond the array alias)
//            DataIn       - store data
//            Dataout      - load data, combinational, zero when no load done
//            stall        - request not accepted this cycle
//            wb_count     - number of buffered stores (registered)
//            commit_count - stores written into the array, wraps at 2^16
//            wb_empty     - buffer holds no stores
// Revision : 1.0 - initial release
// ============================================================================
module dmem_wbuf #(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 16,
    parameter int MEM_DEPTH = 1024,
    parameter int WB_DEPTH  = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      MemRd,
    input  logic                      MemWr,
    input  logic [ADDR_W-1:0]         address,
    input  logic [DATA_W-1:0]         DataIn,
    output logic [DATA_W-1:0]         Dataout,
    output logic                      stall,
    output logic [$clog2(WB_DEPTH):0] wb_count,
    output logic [15:0]               commit_count,
    output logic                      wb_empty
);

    localparam int c_IDX_W = $clog2(MEM_DEPTH);
    localparam int c_PTR_W = $clog2(WB_DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_FULL_CNT = c_CNT_W'(WB_DEPTH);

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    logic [DATA_W-1:0]  r_mem     [MEM_DEPTH];
    logic [c_IDX_W-1:0] r_wb_idx  [WB_DEPTH];
    logic [DATA_W-1:0]  r_wb_data [WB_DEPTH];

    logic [c_PTR_W-1:0] r_head;
    logic [c_PTR_W-1:0] r_tail;
    logic [c_CNT_W-1:0] r_count;
    logic [15:0]        r_commit;

    // ------------------------------------------------------------------
    // Control
    // ------------------------------------------------------------------
    logic               w_full;
    logic               w_empty;
    logic               w_stall;
    logic               w_push;
    logic               w_pop;
    logic               w_load;
    logic [c_IDX_W-1:0] w_idx;
    logic               w_fwd_hit;
    logic [DATA_W-1:0]  w_fwd_data;

    assign w_idx   = address[c_IDX_W-1:0];
    assign w_full  = (r_count == c_FULL_CNT);
    assign w_empty = (r_count == '0);

    // A full buffer forces a drain in the same cycle, so a store is always
    // accepted; only a load against a full buffer has to wait.
    assign w_stall = MemRd & w_full;
    assign w_push  = MemWr & ~w_stall;

    // The array port is owned by the load unless the buffer is full.
    assign w_pop   = ~w_empty & (~MemRd | w_full);

    // No load is performed while reset is held, keeping Dataout at zero.
    assign w_load  = reset & MemRd & ~w_stall;

    // Upper address bits only alias onto the array.
    if (c_IDX_W < ADDR_W) begin : g_addr_alias
        logic w_unused_addr;
        assign w_unused_addr = ^address[ADDR_W-1:c_IDX_W];
    end else begin : g_addr_full
    end

    // ------------------------------------------------------------------
    // Forwarding: walk the live entries from oldest to youngest so the
    // youngest match wins. The store presented this cycle is not yet in the
    // buffer, so the load sees pre-store state.
    // ------------------------------------------------------------------
    always_comb begin
        w_fwd_hit  = 1'b0;
        w_fwd_data = '0;
        for (int i = 0; i < WB_DEPTH; i++) begin
            if ((c_CNT_W'(i) < r_count) &&
                (r_wb_idx[r_head + c_PTR_W'(i)] == w_idx)) begin
                w_fwd_hit  = 1'b1;
                w_fwd_data = r_wb_data[r_head + c_PTR_W'(i)];
            end
        end
    end

    always_comb begin
        Dataout = '0;
        if (w_load) begin
            Dataout = w_fwd_hit ? w_fwd_data : r_mem[w_idx];
        end
    end

    // ------------------------------------------------------------------
    // Buffer pointers and counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_head   <= '0;
            r_tail   <= '0;
            r_count  <= '0;
            r_commit <= '0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + 1'b1;
            end
            if (w_pop) begin
                r_head   <= r_head + 1'b1;
                r_commit <= r_commit + 16'd1;
            end
            // Simultaneous push and pop leaves the occupancy unchanged.
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Buffer payload and array: not reset. Pops cannot happen while reset
    // is held because the count is zero.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_wb_idx[r_tail]  <= w_idx;
            r_wb_data[r_tail] <= DataIn;
        end
    end

    always_ff @(posedge clk) begin
        if (w_pop) begin
            r_mem[r_wb_idx[r_head]] <= r_wb_data[r_head];
        end
    end

    assign stall        = w_stall;
    assign wb_count     = r_count;
    assign commit_count = r_commit;
    assign wb_empty     = w_empty;

endmodule
`default_nettype wire
